// File: rtl/ex_alu_stage.sv
// Execute-stage ALU: saturating CLA add/sub, packed nibble add, shifts/rotate,
// with a registered result, destination tag and Z/V/N flags behind a
// valid/ready handshake. One-cycle latency, flushable.
module ex_alu_stage #(
   parameter int unsigned WIDTH   = 16,
   parameter int unsigned SHAMT_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       opcode,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic [3:0]       dst,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       out_dst,
   output logic             flag_z,
   output logic             flag_v,
   output logic             flag_n
);

   localparam int unsigned NIB_W = 4;
   localparam int unsigned N_NIB = WIDTH / NIB_W;

   localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [NIB_W-1:0] NIB_POS = {1'b0, {(NIB_W-1){1'b1}}};
   localparam logic [NIB_W-1:0] NIB_NEG = {1'b1, {(NIB_W-1){1'b0}}};

   typedef enum logic [2:0] {
      OP_ADD    = 3'd0,
      OP_SUB    = 3'd1,
      OP_XOR    = 3'd2,
      OP_PADDSB = 3'd3,
      OP_SLL    = 3'd4,
      OP_SRA    = 3'd5,
      OP_ROR    = 3'd6,
      OP_PASSB  = 3'd7
   } op_e;

   // Carry-lookahead adder built from 4-bit lookahead groups; the MSB bit of
   // the return value is the signed overflow (carry into vs. out of the MSB).
   function automatic logic [WIDTH:0] cla_add(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             cin);
      logic [WIDTH-1:0] g;
      logic [WIDTH-1:0] p;
      logic [WIDTH:0]   c;
      int unsigned      i;
      g    = a & b;
      p    = a ^ b;
      c    = '0;
      c[0] = cin;
      for (int unsigned k = 0; k < N_NIB; k++) begin
         i = k * NIB_W;
         c[i+1] = g[i] | (p[i] & c[i]);
         c[i+2] = g[i+1] | (p[i+1] & g[i]) | (p[i+1] & p[i] & c[i]);
         c[i+3] = g[i+2] | (p[i+2] & g[i+1]) | (p[i+2] & p[i+1] & g[i])
                | (p[i+2] & p[i+1] & p[i] & c[i]);
         c[i+4] = g[i+3] | (p[i+3] & g[i+2]) | (p[i+3] & p[i+2] & g[i+1])
                | (p[i+3] & p[i+2] & p[i+1] & g[i])
                | (p[i+3] & p[i+2] & p[i+1] & p[i] & c[i]);
      end
      return {c[WIDTH] ^ c[WIDTH-1], p ^ c[WIDTH-1:0]};
   endfunction

   op_e              op;
   logic             is_sub;
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH:0]   cla_out;
   logic [SHAMT_W-1:0] shamt;
   logic [NIB_W:0]   nib_sum;
   logic [WIDTH-1:0] alu_res;
   logic             alu_v;
   logic             upd_z;
   logic             upd_vn;
   logic             capture;

   assign op    = op_e'(opcode);
   assign shamt = op_b[SHAMT_W-1:0];

   // Shared adder: SUB is A + ~B with carry-in set.
   always_comb begin
      is_sub  = (op == OP_SUB);
      b_eff   = is_sub ? ~op_b : op_b;
      cla_out = cla_add(op_a, b_eff, is_sub);
   end

   // Operation select, saturation and which flags the op is allowed to touch.
   always_comb begin
      alu_res = '0;
      alu_v   = 1'b0;
      upd_z   = 1'b0;
      upd_vn  = 1'b0;
      nib_sum = '0;
      unique case (op)
         OP_ADD, OP_SUB: begin
            upd_z  = 1'b1;
            upd_vn = 1'b1;
            alu_v  = cla_out[WIDTH];
            if (cla_out[WIDTH]) alu_res = op_a[WIDTH-1] ? SAT_NEG : SAT_POS;
            else                alu_res = cla_out[WIDTH-1:0];
         end
         OP_XOR: begin
            upd_z   = 1'b1;
            alu_res = op_a ^ op_b;
         end
         OP_PADDSB: begin
            for (int unsigned k = 0; k < N_NIB; k++) begin
               nib_sum = {op_a[k*NIB_W+NIB_W-1], op_a[k*NIB_W +: NIB_W]}
                       + {op_b[k*NIB_W+NIB_W-1], op_b[k*NIB_W +: NIB_W]};
               if (nib_sum[NIB_W] != nib_sum[NIB_W-1])
                  alu_res[k*NIB_W +: NIB_W] = nib_sum[NIB_W] ? NIB_NEG : NIB_POS;
               else
                  alu_res[k*NIB_W +: NIB_W] = nib_sum[NIB_W-1:0];
            end
         end
         OP_SLL: begin
            upd_z   = 1'b1;
            alu_res = op_a << shamt;
         end
         OP_SRA: begin
            upd_z   = 1'b1;
            alu_res = $unsigned($signed(op_a) >>> shamt);
         end
         OP_ROR: begin
            upd_z   = 1'b1;
            alu_res = WIDTH'({op_a, op_a} >> shamt);
         end
         OP_PASSB: begin
            alu_res = op_b;
         end
         default: alu_res = '0;
      endcase
   end

   assign in_ready = ~out_valid | out_ready;
   assign capture  = in_valid & in_ready & ~flush;

   // Output/flag registers: flush beats capture, capture beats drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         out_dst   <= '0;
         flag_z    <= 1'b0;
         flag_v    <= 1'b0;
         flag_n    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (capture) begin
         out_valid <= 1'b1;
         result    <= alu_res;
         out_dst   <= dst;
         if (upd_z) flag_z <= (alu_res == '0);
         if (upd_vn) begin
            flag_v <= alu_v;
            flag_n <= alu_res[WIDTH-1];
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_alu_stage.sv
// Bench for ex_alu_stage: directed vectors with literal expectations plus a
// per-cycle comparison against an arithmetic reference model.
module tb_ex_alu_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  opcode;
   logic [15:0] op_a;
   logic [15:0] op_b;
   logic [3:0]  dst;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic [3:0]  out_dst;
   logic        flag_z;
   logic        flag_v;
   logic        flag_n;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   ex_alu_stage #(.WIDTH(16), .SHAMT_W(4)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
      .in_ready(in_ready), .opcode(opcode), .op_a(op_a), .op_b(op_b),
      .dst(dst), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .out_dst(out_dst), .flag_z(flag_z),
      .flag_v(flag_v), .flag_n(flag_n)
   );

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference behaviour in plain integer arithmetic.
   function automatic void model_exec(input logic [2:0] opc, input logic [15:0] a,
                                      input logic [15:0] b, output logic [15:0] r,
                                      output logic uz, output logic uvn, output logic v);
      int sa, sb, s, x, y, sh;
      logic [3:0] an, bn;
      sa  = int'($signed(a));
      sb  = int'($signed(b));
      sh  = int'(b[3:0]);
      r   = 16'h0;
      uz  = 1'b0;
      uvn = 1'b0;
      v   = 1'b0;
      case (opc)
         3'd0, 3'd1: begin
            s = (opc == 3'd0) ? sa + sb : sa - sb;
            if (s > 32767)       begin s = 32767;  v = 1'b1; end
            else if (s < -32768) begin s = -32768; v = 1'b1; end
            r   = 16'(s);
            uz  = 1'b1;
            uvn = 1'b1;
         end
         3'd2: begin r = a ^ b; uz = 1'b1; end
         3'd3: begin
            for (int n = 0; n < 4; n++) begin
               an = a[4*n +: 4];
               bn = b[4*n +: 4];
               x  = int'($signed(an));
               y  = int'($signed(bn));
               s  = x + y;
               if (s > 7)  s = 7;
               if (s < -8) s = -8;
               r[4*n +: 4] = 4'(s);
            end
         end
         3'd4: begin r = 16'(int'(a) * (2 ** sh)); uz = 1'b1; end
         3'd5: begin r = 16'(sa >>> sh); uz = 1'b1; end
         3'd6: begin
            r = a;
            for (int i = 0; i < sh; i++) r = {r[0], r[15:1]};
            uz = 1'b1;
         end
         default: r = b;
      endcase
   endfunction

   logic        m_valid, m_z, m_v, m_n, m_cap, m_uz, m_uvn, m_ov;
   logic [15:0] m_res, m_r;
   logic [3:0]  m_dst;
   logic        cmp_en = 1'b0;
   logic        prev_valid = 1'b0;
   logic [15:0] prev_res = 16'h0;
   logic [15:0] log_q[$];

   // Reference model state, advanced at every clock edge and on reset.
   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_valid = 1'b0; m_res = 16'h0; m_dst = 4'h0;
            m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
         end else begin
            m_cap = in_valid && (!m_valid || out_ready) && !flush;
            if (flush) m_valid = 1'b0;
            else if (m_cap) begin
               model_exec(opcode, op_a, op_b, m_r, m_uz, m_uvn, m_ov);
               m_res   = m_r;
               m_dst   = dst;
               m_valid = 1'b1;
               if (m_uz) m_z = (m_r == 16'h0);
               if (m_uvn) begin m_v = m_ov; m_n = m_r[15]; end
            end else if (out_ready) m_valid = 1'b0;
         end
      end
   end

   // Per-cycle comparison against the model, plus a log of delivered results.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (cmp_en && rst_n) begin
            chk1("cmp_out_valid", out_valid, m_valid);
            chk1("cmp_in_ready", in_ready, !m_valid || out_ready);
            chk1("cmp_flag_z", flag_z, m_z);
            chk1("cmp_flag_v", flag_v, m_v);
            chk1("cmp_flag_n", flag_n, m_n);
            if (m_valid) begin
               chk16("cmp_result", result, m_res);
               chk16("cmp_out_dst", 16'(out_dst), 16'(m_dst));
            end
            if (prev_valid && out_ready) log_q.push_back(prev_res);
         end
         prev_valid = out_valid;
         prev_res   = result;
      end
   end

   // Presents one op and returns just after the edge that accepted it.
   task automatic send(input logic [2:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [3:0] d);
      logic ok;
      ok = 1'b0;
      @(negedge clk);
      in_valid = 1'b1; opcode = op; op_a = a; op_b = b; dst = d;
      for (int i = 0; i < 50 && !ok; i++) begin
         #1;
         if (in_ready) ok = 1'b1;
         else @(negedge clk);
      end
      chk1("send_accept", ok, 1'b1);
      if (ok) @(posedge clk);
   endtask

   task automatic expect_out(input string name, input logic [15:0] r, input logic [3:0] d,
                             input logic z, input logic v, input logic n);
      chk1({name, "_valid"}, out_valid, 1'b1);
      chk16({name, "_res"}, result, r);
      chk16({name, "_dst"}, 16'(out_dst), 16'(d));
      chk1({name, "_z"}, flag_z, z);
      chk1({name, "_v"}, flag_v, v);
      chk1({name, "_n"}, flag_n, n);
   endtask

   function automatic logic [15:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 16'h7FFF;
         1: return 16'h8000;
         2: return 16'h0000;
         3: return 16'hFFFF;
         default: return 16'($urandom());
      endcase
   endfunction

   typedef struct {
      logic [2:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] r;
      logic        z;
      logic        v;
      logic        n;
   } vec_t;

   // Flags are cumulative: ops that do not touch a flag carry the prior value.
   vec_t vecs[17] = '{
      '{3'd0, 16'h7000, 16'h1000, 16'h7FFF, 1'b0, 1'b1, 1'b0},
      '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b0, 1'b0},
      '{3'd2, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b0, 1'b0},
      '{3'd1, 16'h8000, 16'h0001, 16'h8000, 1'b0, 1'b1, 1'b1},
      '{3'd2, 16'h00FF, 16'h00FF, 16'h0000, 1'b1, 1'b1, 1'b1},
      '{3'd3, 16'h7878, 16'h1818, 16'h7878, 1'b1, 1'b1, 1'b1},
      '{3'd3, 16'h1234, 16'h1111, 16'h2345, 1'b1, 1'b1, 1'b1},
      '{3'd4, 16'h8001, 16'h0004, 16'h0010, 1'b0, 1'b1, 1'b1},
      '{3'd5, 16'h8001, 16'h0004, 16'hF800, 1'b0, 1'b1, 1'b1},
      '{3'd6, 16'h8001, 16'h0004, 16'h1800, 1'b0, 1'b1, 1'b1},
      '{3'd6, 16'h8001, 16'h0000, 16'h8001, 1'b0, 1'b1, 1'b1},
      '{3'd4, 16'h8001, 16'h0014, 16'h0010, 1'b0, 1'b1, 1'b1},
      '{3'd7, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1},
      '{3'd0, 16'h8000, 16'hFFFF, 16'h8000, 1'b0, 1'b1, 1'b1},
      '{3'd1, 16'h7FFF, 16'hFFFF, 16'h7FFF, 1'b0, 1'b1, 1'b0},
      '{3'd0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0},
      '{3'd5, 16'h7FF0, 16'h000F, 16'h0000, 1'b1, 1'b0, 1'b0}
   };

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      opcode = 3'd0; op_a = 16'h0; op_b = 16'h0; dst = 4'h0;

      // Reset state
      repeat (2) @(negedge clk);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk16("rst_result", result, 16'h0);
      chk16("rst_out_dst", 16'(out_dst), 16'h0);
      chk1("rst_flag_z", flag_z, 1'b0);
      chk1("rst_flag_v", flag_v, 1'b0);
      chk1("rst_flag_n", flag_n, 1'b0);
      chk1("rst_in_ready", in_ready, 1'b1);
      rst_n  = 1'b1;
      cmp_en = 1'b1;

      // Directed stream, back to back
      for (int i = 0; i < 17; i++) begin
         send(vecs[i].op, vecs[i].a, vecs[i].b, 4'(i));
         #1;
         expect_out($sformatf("vec%0d", i), vecs[i].r, 4'(i), vecs[i].z, vecs[i].v, vecs[i].n);
      end
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);

      // Back-pressure: A held three cycles while B waits, then A, B, C drain in order
      @(negedge clk);
      log_q.delete();
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 3'd0; op_a = 16'h0001; op_b = 16'h0002; dst = 4'd9;
      @(posedge clk); #1;
      expect_out("bp_a", 16'h0003, 4'd9, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      opcode = 3'd2; op_a = 16'h00F0; op_b = 16'h000F; dst = 4'd10;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1("bp_in_ready_low", in_ready, 1'b0);
         @(posedge clk); #1;
         expect_out("bp_hold", 16'h0003, 4'd9, 1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk1("bp_in_ready_release", in_ready, 1'b1);
      @(negedge clk);
      opcode = 3'd7; op_a = 16'h0000; op_b = 16'h1234; dst = 4'd11;
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #2;
      chk16("bp_count", 16'(log_q.size()), 16'd3);
      if (log_q.size() == 3) begin
         chk16("bp_order0", log_q[0], 16'h0003);
         chk16("bp_order1", log_q[1], 16'h00FF);
         chk16("bp_order2", log_q[2], 16'h1234);
      end

      // Flush with in_valid: result killed, input dropped, flags kept
      send(3'd0, 16'h0001, 16'h0001, 4'd12);
      #1;
      expect_out("fl_pre", 16'h0002, 4'd12, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      flush = 1'b1; opcode = 3'd1; op_a = 16'h0000; op_b = 16'h0001; dst = 4'd13;
      @(posedge clk); #1;
      chk1("fl_out_valid", out_valid, 1'b0);
      chk1("fl_flag_z", flag_z, 1'b0);
      chk1("fl_flag_v", flag_v, 1'b0);
      chk1("fl_flag_n", flag_n, 1'b0);
      @(negedge clk);
      flush = 1'b0; in_valid = 1'b0;
      @(posedge clk); #1;
      chk1("fl_no_retry", out_valid, 1'b0);

      // Reset pulsed mid-cycle during a stall
      @(negedge clk);
      out_ready = 1'b0;
      in_valid = 1'b1; opcode = 3'd0; op_a = 16'h8000; op_b = 16'hFFFF; dst = 4'd14;
      @(posedge clk); #1;
      expect_out("mr_pre", 16'h8000, 4'd14, 1'b0, 1'b1, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      chk1("mr_out_valid", out_valid, 1'b0);
      chk16("mr_result", result, 16'h0);
      chk16("mr_out_dst", 16'(out_dst), 16'h0);
      chk1("mr_flag_z", flag_z, 1'b0);
      chk1("mr_flag_v", flag_v, 1'b0);
      chk1("mr_flag_n", flag_n, 1'b0);
      chk1("mr_in_ready", in_ready, 1'b1);
      #1;
      rst_n = 1'b1;
      out_ready = 1'b1;

      // Random traffic checked by the model
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         opcode    = 3'($urandom_range(0, 7));
         op_a      = rand_operand();
         op_b      = rand_operand();
         dst       = 4'($urandom_range(0, 15));
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 15) == 0);
      end
      @(negedge clk);
      in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
